// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the load/store memory port arbiter: FSM encoding,
// store-FIFO entry layout and watchdog sizing.
package mem_port_arbiter_pkg;

    localparam int PACK_WIDTH_DEF = 71;

    // Bit positions of the store-FIFO head entry
    localparam int PACK_WR_BIT    = 70;
    localparam int PACK_SIZE_MSB  = 69;
    localparam int PACK_SIZE_LSB  = 68;
    localparam int PACK_WSTRB_MSB = 67;
    localparam int PACK_WSTRB_LSB = 64;
    localparam int PACK_ADDR_MSB  = 63;
    localparam int PACK_ADDR_LSB  = 32;
    localparam int PACK_WDATA_MSB = 31;
    localparam int PACK_WDATA_LSB = 0;

    localparam int WD_WIDTH      = 8;
    localparam int STARVE_WIDTH  = 3;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } store_pack_t;

    localparam int PACK_BITS = $bits(store_pack_t);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LD_REQ  = 3'd1,
        LD_WAIT = 3'd2,
        ST_REQ  = 3'd3,
        ST_WAIT = 3'd4
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Response watchdog: counts cycles spent waiting for data_ok and flags
// when the wait reaches the programmed limit.
module mem_watchdog
    import mem_port_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic                enable,
    input  logic                clear,
    input  logic [WD_WIDTH-1:0] limit,
    output logic                expired
);

    logic [WD_WIDTH-1:0] count_q;
    logic [WD_WIDTH-1:0] count_d;

    // Count while enabled, hold at the limit so the counter never wraps
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != limit)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && (count_q == limit);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a load requester and a store FIFO onto one memory bus, with a
// starvation limit on loads, a drain (sync) request and a response watchdog.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int PACK_WIDTH   = PACK_WIDTH_DEF,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [PACK_WIDTH-1:0] fifo_rdata_pack,
    input  logic                  fifo_is_empty,
    input  logic                  fifo_is_full,
    output logic                  fifo_complete,
    input  logic                  ld_req,
    input  logic [1:0]            ld_size,
    input  logic [31:0]           ld_addr,
    output logic                  ld_addr_ok,
    output logic                  ld_data_ok,
    output logic [31:0]           ld_rdata,
    output logic                  data_req,
    output logic                  data_wr,
    output logic [1:0]            data_size,
    output logic [3:0]            data_wstrb,
    output logic [31:0]           data_addr,
    output logic [31:0]           data_wdata,
    input  logic                  data_addr_ok,
    input  logic                  data_data_ok,
    input  logic [31:0]           data_rdata,
    input  logic                  sync_req,
    output logic                  sync_done,
    output logic                  bus_err
);

    localparam logic [STARVE_WIDTH-1:0] STARVE_MAX = STARVE_WIDTH'(STARVE_LIMIT);
    localparam logic [WD_WIDTH-1:0]     WD_LIMIT   = WD_WIDTH'(TIMEOUT);

    arb_state_e state_q, state_d;
    logic [STARVE_WIDTH-1:0] starveCnt_q, starveCnt_d;
    logic        reqWr_q, reqWr_d;
    logic [1:0]  reqSize_q, reqSize_d;
    logic [3:0]  reqWstrb_q, reqWstrb_d;
    logic [31:0] reqAddr_q, reqAddr_d;
    logic [31:0] reqWdata_q, reqWdata_d;
    logic        busErr_q;
    logic        loadGrant;
    logic        storeGrant;
    logic        inWait;
    logic        wdExpired;
    store_pack_t headPack;

    assign headPack = store_pack_t'(fifo_rdata_pack[PACK_BITS-1:0]);
    assign inWait   = (state_q == LD_WAIT) || (state_q == ST_WAIT);

    // IDLE decision: loads win unless draining, the FIFO is full, or loads have starved stores
    always_comb begin
        loadGrant  = 1'b0;
        storeGrant = 1'b0;
        if (state_q == IDLE) begin
            if (ld_req && !sync_req && !fifo_is_full &&
                ((starveCnt_q < STARVE_MAX) || fifo_is_empty)) begin
                loadGrant = 1'b1;
            end else if (!fifo_is_empty) begin
                storeGrant = 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (loadGrant) begin
                    state_d = LD_REQ;
                end else if (storeGrant) begin
                    state_d = ST_REQ;
                end
            end
            LD_REQ:  if (data_addr_ok) state_d = LD_WAIT;
            LD_WAIT: if (data_data_ok) state_d = IDLE;
            ST_REQ:  if (data_addr_ok) state_d = ST_WAIT;
            ST_WAIT: if (data_data_ok) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture the granted request so the bus sees stable fields for its whole life
    always_comb begin
        reqWr_d    = reqWr_q;
        reqSize_d  = reqSize_q;
        reqWstrb_d = reqWstrb_q;
        reqAddr_d  = reqAddr_q;
        reqWdata_d = reqWdata_q;
        if (loadGrant) begin
            reqWr_d    = 1'b0;
            reqSize_d  = ld_size;
            reqWstrb_d = 4'd0;
            reqAddr_d  = ld_addr;
            reqWdata_d = 32'd0;
        end else if (storeGrant) begin
            reqWr_d    = headPack.wr;
            reqSize_d  = headPack.size;
            reqWstrb_d = headPack.wstrb;
            reqAddr_d  = headPack.addr;
            reqWdata_d = headPack.wdata;
        end
    end

    // Consecutive loads granted over waiting stores, saturating at the limit
    always_comb begin
        starveCnt_d = starveCnt_q;
        if (fifo_is_empty || storeGrant) begin
            starveCnt_d = '0;
        end else if (loadGrant && (starveCnt_q < STARVE_MAX)) begin
            starveCnt_d = starveCnt_q + 1'b1;
        end
    end

    // Request, starvation and error registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            reqWr_q     <= 1'b0;
            reqSize_q   <= '0;
            reqWstrb_q  <= '0;
            reqAddr_q   <= '0;
            reqWdata_q  <= '0;
            starveCnt_q <= '0;
            busErr_q    <= 1'b0;
        end else begin
            reqWr_q     <= reqWr_d;
            reqSize_q   <= reqSize_d;
            reqWstrb_q  <= reqWstrb_d;
            reqAddr_q   <= reqAddr_d;
            reqWdata_q  <= reqWdata_d;
            starveCnt_q <= starveCnt_d;
            busErr_q    <= busErr_q | wdExpired;
        end
    end

    mem_watchdog uWatchdog (
        .clk     (clk),
        .resetn  (resetn),
        .enable  (inWait),
        .clear   (!inWait || data_data_ok),
        .limit   (WD_LIMIT),
        .expired (wdExpired)
    );

    // FSM outputs: bus fields only while requesting, handshakes only in their own state
    always_comb begin
        data_req      = 1'b0;
        data_wr       = 1'b0;
        data_size     = 2'd0;
        data_wstrb    = 4'd0;
        data_addr     = 32'd0;
        data_wdata    = 32'd0;
        ld_addr_ok    = 1'b0;
        ld_data_ok    = 1'b0;
        ld_rdata      = 32'd0;
        fifo_complete = 1'b0;
        case (state_q)
            LD_REQ, ST_REQ: begin
                data_req   = 1'b1;
                data_wr    = reqWr_q;
                data_size  = reqSize_q;
                data_wstrb = reqWstrb_q;
                data_addr  = reqAddr_q;
                data_wdata = reqWdata_q;
                ld_addr_ok = (state_q == LD_REQ) && data_addr_ok;
            end
            LD_WAIT: begin
                if (data_data_ok) begin
                    ld_data_ok = 1'b1;
                    ld_rdata   = data_rdata;
                end
            end
            ST_WAIT: begin
                fifo_complete = data_data_ok;
            end
            default: ;
        endcase
    end

    assign sync_done = resetn && sync_req && (state_q == IDLE) && fifo_is_empty;
    assign bus_err   = busErr_q || wdExpired;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small store-FIFO and bus model.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int PACK_W     = PACK_WIDTH_DEF;
    localparam int FIFO_DEPTH = 4;

    logic              clk;
    logic              resetn;
    logic [PACK_W-1:0] fifo_rdata_pack;
    logic              fifo_is_empty;
    logic              fifo_is_full;
    logic              fifo_complete;
    logic              ld_req;
    logic [1:0]        ld_size;
    logic [31:0]       ld_addr;
    logic              ld_addr_ok;
    logic              ld_data_ok;
    logic [31:0]       ld_rdata;
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [3:0]        data_wstrb;
    logic [31:0]       data_addr;
    logic [31:0]       data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [31:0]       data_rdata;
    logic              sync_req;
    logic              sync_done;
    logic              bus_err;

    logic              busAddrOkEn;
    logic              busDataOkEn;
    logic [31:0]       busRdata;
    logic [PACK_W-1:0] fifoMem [16];
    int                pushCount = 0;
    int                popCount = 0;
    int                grantTotal = 0;
    int                loadGrantTotal = 0;
    logic              grantWr [64];
    int                errors;
    int                checks;
    logic [108:0]      outBundle;

    mem_port_arbiter dut (
        .clk             (clk),
        .resetn          (resetn),
        .fifo_rdata_pack (fifo_rdata_pack),
        .fifo_is_empty   (fifo_is_empty),
        .fifo_is_full    (fifo_is_full),
        .fifo_complete   (fifo_complete),
        .ld_req          (ld_req),
        .ld_size         (ld_size),
        .ld_addr         (ld_addr),
        .ld_addr_ok      (ld_addr_ok),
        .ld_data_ok      (ld_data_ok),
        .ld_rdata        (ld_rdata),
        .data_req        (data_req),
        .data_wr         (data_wr),
        .data_size       (data_size),
        .data_wstrb      (data_wstrb),
        .data_addr       (data_addr),
        .data_wdata      (data_wdata),
        .data_addr_ok    (data_addr_ok),
        .data_data_ok    (data_data_ok),
        .data_rdata      (data_rdata),
        .sync_req        (sync_req),
        .sync_done       (sync_done),
        .bus_err         (bus_err)
    );

    assign fifo_is_empty   = (pushCount == popCount);
    assign fifo_is_full    = ((pushCount - popCount) == FIFO_DEPTH);
    assign fifo_rdata_pack = fifoMem[popCount[3:0]];
    assign data_addr_ok    = busAddrOkEn && data_req;
    assign data_data_ok    = busDataOkEn;
    assign data_rdata      = busRdata;
    assign outBundle = {fifo_complete, ld_addr_ok, ld_data_ok, ld_rdata, data_req, data_wr,
                        data_size, data_wstrb, data_addr, data_wdata, sync_done, bus_err};

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The FIFO pops its head whenever the arbiter strobes completion
    always @(negedge clk) begin
        if (fifo_complete) popCount++;
    end

    // Record every accepted bus request in order (0 = load, 1 = store)
    always @(negedge clk) begin
        if (resetn && data_req && data_addr_ok) begin
            grantWr[grantTotal % 64] = data_wr;
            grantTotal++;
            if (!data_wr) loadGrantTotal++;
        end
    end

    // Hard stop if the sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: observed=stalled expected=finished");
        $fatal(1, "[TB] simulation stalled");
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ldReq, input logic syncReq,
                                 input logic addrOkEn, input logic dataOkEn);
        ld_req      = ldReq;
        sync_req    = syncReq;
        busAddrOkEn = addrOkEn;
        busDataOkEn = dataOkEn;
        #1;
    endtask

    task automatic pushStore(input logic [31:0] addr, input logic [31:0] wdata);
        fifoMem[pushCount[3:0]] = {1'b1, 2'd2, 4'hF, addr, wdata};
        pushCount++;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic waitDrain(input string tag);
        int cyc;
        cyc = 0;
        while (!fifo_is_empty && cyc < 60) begin
            nextCycle();
            cyc++;
        end
        checkOutput(tag, fifo_is_empty, 1);
        repeat (3) nextCycle();
    endtask

    initial begin
        int base;
        int cyc;
        int popBase;
        int loadBase;
        logic [9:0] grantVec;
        logic [1:0] grantPair;

        errors = 0;
        checks = 0;
        resetn = 1'b0;
        ld_req = 1'b0;
        ld_size = 2'd0;
        ld_addr = 32'd0;
        sync_req = 1'b0;
        busAddrOkEn = 1'b0;
        busDataOkEn = 1'b0;
        busRdata = 32'd0;

        // Reset state
        #2;
        checkOutput("reset_outputs", outBundle, 0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        #1;
        checkOutput("idle_after_reset", outBundle, 0);

        // Single store with immediate bus handshakes
        nextCycle();
        pushStore(32'h100, 32'hDEADBEEF);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("st_decision_no_req", data_req, 0);
        nextCycle(); #1;
        checkOutput("st_req_data_req", data_req, 1);
        checkOutput("st_req_data_wr", data_wr, 1);
        checkOutput("st_req_addr", data_addr, 32'h100);
        checkOutput("st_req_wdata", data_wdata, 32'hDEADBEEF);
        checkOutput("st_req_wstrb", data_wstrb, 4'hF);
        checkOutput("st_req_no_complete", fifo_complete, 0);
        nextCycle(); #1;
        checkOutput("st_wait_complete", fifo_complete, 1);
        checkOutput("st_wait_no_req", data_req, 0);
        nextCycle(); #1;
        checkOutput("st_done_quiet", {fifo_complete, data_req}, 0);
        checkOutput("st_done_popped", fifo_is_empty, 1);

        // Single load with the FIFO empty
        nextCycle();
        ld_addr = 32'h200;
        ld_size = 2'd1;
        busRdata = 32'h12345678;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("ld_decision_no_req", data_req, 0);
        nextCycle(); #1;
        checkOutput("ld_req_fields", {data_req, data_wr, data_size, data_wstrb, data_addr},
                    {1'b1, 1'b0, 2'd1, 4'h0, 32'h200});
        checkOutput("ld_addr_ok", {ld_addr_ok, ld_data_ok}, 2'b10);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("ld_data_ok", {ld_addr_ok, ld_data_ok}, 2'b01);
        checkOutput("ld_rdata", ld_rdata, 32'h12345678);
        nextCycle(); #1;
        checkOutput("ld_done_quiet", {ld_data_ok, ld_rdata, data_req}, 0);

        // Loads held high against three queued stores
        nextCycle();
        base = grantTotal;
        ld_addr = 32'h300;
        pushStore(32'h310, 32'h1);
        pushStore(32'h320, 32'h2);
        pushStore(32'h330, 32'h3);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        cyc = 0;
        while ((grantTotal - base) < 10 && cyc < 100) begin
            nextCycle();
            cyc++;
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("starve_grants_seen", (grantTotal - base) >= 10, 1);
        for (int i = 0; i < 10; i++) grantVec[9 - i] = grantWr[(base + i) % 64];
        checkOutput("starve_grant_order", grantVec, 10'b0000100001);
        waitDrain("starve_drain");

        // Full FIFO takes priority even with a fresh starvation count
        nextCycle();
        base = grantTotal;
        for (int i = 0; i < 4; i++) pushStore(32'h600 + 32'(i), 32'hA0 + 32'(i));
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("full_flag", fifo_is_full, 1);
        cyc = 0;
        while ((grantTotal - base) < 2 && cyc < 20) begin
            nextCycle();
            cyc++;
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        grantPair = {grantWr[base % 64], grantWr[(base + 1) % 64]};
        checkOutput("full_store_first", grantPair, 2'b10);
        waitDrain("full_drain");

        // Drain request with two stores queued and a load pending
        nextCycle();
        popBase = popCount;
        loadBase = loadGrantTotal;
        pushStore(32'h700, 32'h77);
        pushStore(32'h704, 32'h78);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("sync_not_done_queued", sync_done, 0);
        cyc = 0;
        while (!sync_done && cyc < 40) begin
            nextCycle(); #1;
            cyc++;
        end
        checkOutput("sync_done_latency", cyc, 6);
        checkOutput("sync_two_pops", popCount - popBase, 2);
        checkOutput("sync_no_load", loadGrantTotal - loadBase, 0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("sync_done_drops", sync_done, 0);
        nextCycle(); #1;
        checkOutput("load_after_sync", {data_req, data_wr}, 2'b10);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (3) nextCycle();

        // Watchdog: withhold data_ok in ST_WAIT for 300 cycles
        nextCycle();
        pushStore(32'h400, 32'hCAFEF00D);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        nextCycle(); #1;
        checkOutput("wd_st_req", data_req, 1);
        nextCycle(); #1;
        checkOutput("wd_start_clear", bus_err, 0);
        repeat (254) nextCycle();
        #1;
        checkOutput("wd_before_limit", bus_err, 0);
        nextCycle(); #1;
        checkOutput("wd_at_limit", bus_err, 1);
        repeat (44) nextCycle();
        #1;
        checkOutput("wd_still_waiting", {bus_err, fifo_complete}, 2'b10);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("wd_late_complete", fifo_complete, 1);
        nextCycle(); #1;
        checkOutput("wd_sticky", {bus_err, fifo_complete, data_req}, 3'b100);

        // Reset asserted in the middle of a store wait
        nextCycle();
        pushStore(32'h500, 32'h55AA55AA);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        nextCycle();
        nextCycle(); #1;
        resetn = 1'b0;
        busDataOkEn = 1'b1;
        #1;
        checkOutput("reset_mid_wait_outputs", outBundle, 0);
        nextCycle();
        nextCycle(); #1;
        checkOutput("reset_held_outputs", outBundle, 0);
        checkOutput("reset_no_pop", pushCount - popCount, 1);
        nextCycle();
        resetn = 1'b1;
        busDataOkEn = 1'b0;
        #1;
        checkOutput("release_idle", data_req, 0);
        nextCycle(); #1;
        checkOutput("regrant_after_reset", {data_req, data_wr, data_addr},
                    {1'b1, 1'b1, 32'h500});
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        waitDrain("reset_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter PACK_WIDTH, default 71, SHALL set the width of the store-FIFO entry.
REQ-002 Parameter STARVE_LIMIT, default 4, SHALL set the maximum consecutive load grants while stores are pending.
REQ-003 Parameter TIMEOUT, default 255, SHALL set the data_ok watchdog limit in cycles (8-bit counter).
REQ-004 clk  in  1  single clock; all state SHALL update on posedge clk.
REQ-005 resetn  in  1  reset; asynchronous, active-low.
REQ-006 fifo_rdata_pack  in  PACK_WIDTH  store-FIFO head: [70] wr, [69:68] size, [67:64] wstrb, [63:32] addr, [31:0] wdata.
REQ-007 fifo_is_empty  in  1  store FIFO holds no entries.
REQ-008 fifo_is_full  in  1  store FIFO full.
REQ-009 fifo_complete  out  1  one-cycle pop strobe to the store FIFO.
REQ-010 ld_req, ld_size[1:0], ld_addr[31:0]  in  load requester; level request, fields stable while ld_req=1.
REQ-011 ld_addr_ok, ld_data_ok  out  1 each  load handshake pulses; ld_rdata  out  32  load return data.
REQ-012 data_req, data_wr, data_size[1:0], data_wstrb[3:0], data_addr[31:0], data_wdata[31:0]  out  shared memory bus request.
REQ-013 data_addr_ok, data_data_ok  in  1 each; data_rdata  in  32  shared memory bus response.
REQ-014 sync_req  in  1  drain request; sync_done  out  1  drain complete.
REQ-015 bus_err  out  1  sticky watchdog flag.

Function
REQ-016 The FSM SHALL have states IDLE, LD_REQ, LD_WAIT, ST_REQ, ST_WAIT.
REQ-017 IDLE: if ld_req and ~sync_req and (starve_cnt < STARVE_LIMIT or fifo_is_empty), SHALL latch ld_* and enter LD_REQ next cycle.
REQ-018 IDLE: otherwise, if ~fifo_is_empty, SHALL latch fifo_rdata_pack and enter ST_REQ next cycle; else stay IDLE.
REQ-019 fifo_is_full SHALL force store priority in IDLE regardless of starve_cnt.
REQ-020 LD_REQ/ST_REQ: data_req=1 with latched fields; data_wr=0 for loads, data_wr=1 for stores; data_wstrb=0 for loads.
REQ-021 LD_REQ/ST_REQ: on data_addr_ok=1, SHALL move to LD_WAIT/ST_WAIT next cycle; ld_addr_ok SHALL equal data_addr_ok in LD_REQ.
REQ-022 In all states other than *_REQ, data_req SHALL be 0 and bus fields SHALL be 0.
REQ-023 LD_WAIT: on data_data_ok, ld_data_ok=1 and ld_rdata=data_rdata in the same cycle; next state IDLE.
REQ-024 ST_WAIT: on data_data_ok, fifo_complete=1 in the same cycle; next state IDLE; fifo_complete SHALL be 0 otherwise.
REQ-025 data_data_ok in any non-WAIT state SHALL be ignored.
REQ-026 starve_cnt (3-bit): +1 on each load grant while ~fifo_is_empty, saturating at STARVE_LIMIT; cleared on store grant or when fifo_is_empty.
REQ-027 sync_done SHALL be 1 exactly when sync_req=1, state=IDLE and fifo_is_empty=1.
REQ-028 While sync_req=1, loads SHALL NOT be granted; stores drain back-to-back (IDLE one cycle between entries).
REQ-029 Watchdog: 8-bit counter increments each cycle in LD_WAIT/ST_WAIT, clears on leaving; reaching TIMEOUT SHALL set bus_err; FSM keeps waiting.
REQ-030 Load-after-store hazards SHALL NOT be checked here; requester issues sync_req first.
REQ-031 Each request/response latency: grant 1 cycle after IDLE decision; no combinational path from ld_req to data_req.

Reset
REQ-032 resetn=0 SHALL asynchronously force state IDLE, starve_cnt=0, watchdog=0, bus_err=0, latched fields=0.
REQ-033 During and after reset all outputs SHALL be 0; reset mid-transaction abandons it without fifo_complete.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding, PACK_WIDTH and pack bit-field positions.
REQ-035 The watchdog SHALL be a sub-module mem_watchdog (enable, clear, limit -> expired).

Verification
REQ-036 Store only: one entry addr=0x100,wdata=0xDEADBEEF, addr_ok/data_ok immediate -> data_req one cycle, data_wr=1, fifo_complete one pulse.
REQ-037 Load only, FIFO empty: ld_addr=0x200, data_rdata=0x12345678 -> ld_addr_ok then ld_data_ok with ld_rdata=0x12345678.
REQ-038 ld_req held high, FIFO 3 entries -> grant order L,L,L,L,S,L,L,L,L,S...
REQ-039 sync_req with 2 queued stores and ld_req=1 -> both stores drained, no load grant, sync_done=1 after second fifo_complete.
REQ-040 data_data_ok withheld 300 cycles in ST_WAIT -> bus_err=1 at cycle 255, stays set; completion still pops.
REQ-041 resetn low in ST_WAIT -> all outputs 0 immediately, no fifo_complete, IDLE after release.
